flag_reg_bank: RTL and testbench

Parametrised CPU status-flag register bank with a hardware shadow stack for nested interrupts. Holds NUM_FLAGS independent flags (C, Z, …), each with clear/set/load control from the control unit. Flags are saved onto a SHAD_DEPTH-deep stack on interrupt entry and restored on return-from-interrupt. Sits between the ALU flag outputs and the control unit / branch logic, replacing the single-bit carry and zero flag registers.

---
 rtl/flag_pkg.sv | 30 +++
 rtl/flag_bit.sv | 41 ++++
 rtl/flag_reg_bank.sv | 123 ++++++++++++
 tb/tb_flag_reg_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared constants and types for the status-flag register bank.
// Flag indices, default geometry and the shadow-stack operation decode.
package flag_pkg;

    localparam int unsigned FLG_C          = 0;
    localparam int unsigned FLG_Z          = 1;
    localparam int unsigned DEF_NUM_FLAGS  = 2;
    localparam int unsigned DEF_SHAD_DEPTH = 4;

    // What the shadow stack does on the coming edge.
    typedef enum logic [1:0] {
        OpHold,
        OpPush,
        OpPop,
        OpFault
    } shad_op_e;

    // Push and pop together cancel out and are never a fault.
    function automatic shad_op_e decode_op(input logic push, input logic pop,
                                           input logic full, input logic empty);
        if (push && !pop) begin
            return full ? OpFault : OpPush;
        end
        if (pop && !push) begin
            return empty ? OpFault : OpPop;
        end
        return OpHold;
    endfunction

endpackage

// File: rtl/flag_bit.sv
// One status flag: priority mux (restore > clr > set > ld > hold) and its flop.
module flag_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic restore,
    input  logic restore_val,
    input  logic clr,
    input  logic set,
    input  logic ld,
    input  logic din,
    output logic q
);

    logic flag_q, flag_d;

    // Next-state priority mux.
    always_comb begin
        flag_d = flag_q;
        if (restore) begin
            flag_d = restore_val;
        end else if (clr) begin
            flag_d = 1'b0;
        end else if (set) begin
            flag_d = 1'b1;
        end else if (ld) begin
            flag_d = din;
        end
    end

    // Flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q = flag_q;

endmodule

// File: rtl/flag_reg_bank.sv
// Status-flag register bank with a LIFO shadow stack for nested interrupts.
// Optional macro SHAD_ERR_EN compiles in the sticky overflow/underflow flag;
// without it shad_err is tied low and err_clr is ignored.
module flag_reg_bank
    import flag_pkg::*;
#(
    parameter int unsigned NUM_FLAGS  = DEF_NUM_FLAGS,
    parameter int unsigned SHAD_DEPTH = DEF_SHAD_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_FLAGS-1:0]               flg_in,
    input  logic [NUM_FLAGS-1:0]               flg_ld,
    input  logic [NUM_FLAGS-1:0]               flg_set,
    input  logic [NUM_FLAGS-1:0]               flg_clr,
    input  logic                               shad_push,
    input  logic                               shad_pop,
    input  logic                               err_clr,
    output logic [NUM_FLAGS-1:0]               flg_out,
    output logic [$clog2(SHAD_DEPTH+1)-1:0]    shad_cnt,
    output logic                               shad_empty,
    output logic                               shad_full,
    output logic                               shad_err
);

    localparam int unsigned CntW = $clog2(SHAD_DEPTH + 1);

    logic [NUM_FLAGS-1:0] stack_q [SHAD_DEPTH];
    logic [NUM_FLAGS-1:0] stack_d [SHAD_DEPTH];
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NUM_FLAGS-1:0] flg_q;
    logic [NUM_FLAGS-1:0] top_val;
    logic                 restore;
    shad_op_e             op;

    assign shad_empty = (cnt_q == '0);
    assign shad_full  = (cnt_q == CntW'(SHAD_DEPTH));
    assign op         = decode_op(shad_push, shad_pop, shad_full, shad_empty);
    assign restore    = (op == OpPop);

    // Top-of-stack read mux; only meaningful when the stack is non-empty.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < int'(SHAD_DEPTH); i++) begin
            if (cnt_q == CntW'(i + 1)) begin
                top_val = stack_q[i];
            end
        end
    end

    // Stack write and occupancy update; faults leave both untouched.
    always_comb begin
        stack_d = stack_q;
        cnt_d   = cnt_q;
        unique case (op)
            OpPush: begin
                for (int i = 0; i < int'(SHAD_DEPTH); i++) begin
                    if (cnt_q == CntW'(i)) begin
                        stack_d[i] = flg_q;
                    end
                end
                cnt_d = cnt_q + CntW'(1);
            end
            OpPop:   cnt_d = cnt_q - CntW'(1);
            default: ;
        endcase
    end

    // Stack entries and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(SHAD_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            stack_q <= stack_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_FLAGS); g++) begin : g_flag
        flag_bit u_flag_bit (
            .clk         (clk),
            .rst_n       (rst_n),
            .restore     (restore),
            .restore_val (top_val[g]),
            .clr         (flg_clr[g]),
            .set         (flg_set[g]),
            .ld          (flg_ld[g]),
            .din         (flg_in[g]),
            .q           (flg_q[g])
        );
    end

    assign flg_out  = flg_q;
    assign shad_cnt = cnt_q;

`ifdef SHAD_ERR_EN
    logic err_q, err_d;

    // Sticky error; a new fault beats a simultaneous clear.
    always_comb begin
        err_d = (op == OpFault) | (err_q & ~err_clr);
    end

    // Error flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign shad_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign shad_err       = 1'b0;
`endif

endmodule

// File: tb/tb_flag_reg_bank.sv
// Self-checking bench for flag_reg_bank: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_flag_reg_bank;

    localparam int unsigned NF    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef SHAD_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] flg_in, flg_ld, flg_set, flg_clr;
    logic          shad_push, shad_pop, err_clr;
    logic [NF-1:0] flg_out;
    logic [CW-1:0] shad_cnt;
    logic          shad_empty, shad_full, shad_err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit [NF-1:0] m_flags;
    bit [NF-1:0] m_stack[$];
    bit          m_err;

    flag_reg_bank #(
        .NUM_FLAGS  (NF),
        .SHAD_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flg_in     (flg_in),
        .flg_ld     (flg_ld),
        .flg_set    (flg_set),
        .flg_clr    (flg_clr),
        .shad_push  (shad_push),
        .shad_pop   (shad_pop),
        .err_clr    (err_clr),
        .flg_out    (flg_out),
        .shad_cnt   (shad_cnt),
        .shad_empty (shad_empty),
        .shad_full  (shad_full),
        .shad_err   (shad_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_flg"},   32'(flg_out),    32'(m_flags));
        chk({tag, "_cnt"},   32'(shad_cnt),   32'(m_stack.size()));
        chk({tag, "_empty"}, 32'(shad_empty), 32'(m_stack.size() == 0));
        chk({tag, "_full"},  32'(shad_full),  32'(m_stack.size() == DEPTH));
        chk({tag, "_err"},   32'(shad_err),   32'(m_err));
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_stack.delete();
        m_err   = 1'b0;
    endtask

    // One clock of the specified behaviour, written from the rules directly.
    task automatic model_step(input bit [NF-1:0] ld, set, clr, din,
                              input bit push, pop, eclr);
        bit [NF-1:0] nf;
        bit          fault;
        fault = 1'b0;
        nf    = ~clr & (set | (ld & din) | (~ld & m_flags));
        if (push && !pop) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else fault = 1'b1;
        end else if (pop && !push) begin
            if (m_stack.size() > 0) nf = m_stack.pop_back();
            else fault = 1'b1;
        end
        m_err   = ErrEn && (fault || (m_err && !eclr));
        m_flags = nf;
    endtask

    // Drive one cycle of inputs, clock it, then check everything 1 ns later.
    task automatic cycle(input string tag, input logic [NF-1:0] ld, set, clr, din,
                         input logic push, pop, eclr);
        flg_ld    = ld;
        flg_set   = set;
        flg_clr   = clr;
        flg_in    = din;
        shad_push = push;
        shad_pop  = pop;
        err_clr   = eclr;
        model_step(ld, set, clr, din, push, pop, eclr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        flg_ld    = '0;
        flg_set   = '0;
        flg_clr   = '0;
        flg_in    = '0;
        shad_push = 1'b0;
        shad_pop  = 1'b0;
        err_clr   = 1'b0;
    endtask

    // Reset asserted between edges must act without waiting for a clock.
    task automatic mid_reset(input string tag);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Priority: clear wins over set and load.
        cycle("prio", 2'b11, 2'b11, 2'b11, 2'b01, 0, 0, 0);
        chk("prio_lit", 32'(flg_out), 32'h0);

        // Save/restore with live update on push and override on pop.
        cycle("ld01", 2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 0);
        cycle("push_ld", 2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 0);
        chk("push_ld_lit", 32'(flg_out), 32'h2);
        chk("push_ld_cnt", 32'(shad_cnt), 32'h1);
        cycle("pop_set", 2'b00, 2'b11, 2'b00, 2'b00, 0, 1, 0);
        chk("pop_set_lit", 32'(flg_out), 32'h1);

        // Nesting: push 00, 01, 10, 11.
        cycle("n_ld", 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        cycle("n_p0", 2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 0);
        cycle("n_p1", 2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 0);
        cycle("n_p2", 2'b11, 2'b00, 2'b00, 2'b11, 1, 0, 0);
        cycle("n_p3", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        chk("n_full_lit", 32'(shad_full), 32'h1);

        // Overflow, then clear the error.
        cycle("ovf", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        chk("ovf_cnt_lit", 32'(shad_cnt), 32'h4);
        chk("ovf_err_lit", 32'(shad_err), 32'(ErrEn));
        cycle("eclr", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);

        // LIFO unwind.
        cycle("u_p0", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("u_p0_lit", 32'(flg_out), 32'h3);
        cycle("u_p1", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("u_p1_lit", 32'(flg_out), 32'h2);
        cycle("u_p2", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("u_p2_lit", 32'(flg_out), 32'h1);
        cycle("u_p3", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("u_p3_lit", 32'(flg_out), 32'h0);
        chk("u_empty_lit", 32'(shad_empty), 32'h1);

        // Underflow: flags follow the load, no restore.
        cycle("udf", 2'b01, 2'b00, 2'b00, 2'b01, 0, 1, 0);
        chk("udf_flg_lit", 32'(flg_out[0]), 32'h1);
        chk("udf_err_lit", 32'(shad_err), 32'(ErrEn));

        // New fault in the same cycle as err_clr keeps the error set.
        cycle("udf_clr", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1);
        cycle("eclr2", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);

        // Simultaneous push and pop at depth 2.
        cycle("s_p0", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        cycle("s_p1", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        cycle("s_both", 2'b11, 2'b00, 2'b00, 2'b10, 1, 1, 0);
        chk("s_both_cnt_lit", 32'(shad_cnt), 32'h2);
        chk("s_both_flg_lit", 32'(flg_out), 32'h2);
        chk("s_both_err_lit", 32'(shad_err), 32'h0);

        // Asynchronous reset mid-operation.
        mid_reset("mrst");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 96) begin
                mid_reset("rrst");
            end else begin
                cycle("rnd",
                      NF'($urandom_range(0, 3)) & NF'($urandom_range(0, 3)),
                      NF'($urandom_range(0, 3)) & NF'($urandom_range(0, 3)),
                      NF'($urandom_range(0, 3)) & NF'($urandom_range(0, 3)),
                      NF'($urandom_range(0, 3)),
                      ($urandom_range(0, 99) < 40),
                      ($urandom_range(0, 99) < 35),
                      ($urandom_range(0, 99) < 10));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
